seq_booth_multiplier: RTL

//  Sequential signed radix-2 Booth multiplier: the shared multiply unit in the complex-multiplier datapath.

---
 rtl/seq_booth_multiplier_pkg.sv | 34 +++
 rtl/seq_booth_multiplier_booth_step.sv | 49 ++++
 rtl/seq_booth_multiplier.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seq_booth_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// cmul_pkg
// Shared definitions for the complex-multiplier datapath: multiplier FSM state
// encoding, the default operand width and the radix-2 Booth operation codes.
// -----------------------------------------------------------------------------
package cmul_pkg;

    // Default operand width of the complex-multiplier datapath.
    localparam int CMUL_WIDTH = 8;

    // Multiplier FSM states. ZERO is only reachable when ZERO_BYPASS_EN is defined.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2
    } mulState_t;

    // Booth operation codes applied to the accumulator.
    localparam logic [1:0] BOOTH_NOP = 2'b00;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // Radix-2 Booth recoding of the pair {q[0], q_m1}.
    function automatic logic [1:0] boothOp(input logic qLsb, input logic qM1);
        logic [1:0] op;
        case ({qLsb, qM1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/seq_booth_multiplier_booth_step.sv
// -----------------------------------------------------------------------------
// booth_step
// One combinational radix-2 Booth iteration: add/subtract/no-op of the
// multiplicand into the accumulator, then arithmetic shift right by one of the
// concatenation {acc, q, qM1}.
// Ports:
//   acc      in  WIDTH+1  current accumulator (signed)
//   m        in  WIDTH+1  sign-extended multiplicand
//   q        in  WIDTH    current multiplier / low product bits
//   qM1      in  1        previously shifted-out multiplier bit
//   accNext  out WIDTH+1  accumulator after the step
//   qNext    out WIDTH    q after the step
//   qM1Next  out 1        qM1 after the step
// -----------------------------------------------------------------------------
module booth_step
    import cmul_pkg::*;
#(
    parameter int WIDTH = CMUL_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH:0]   m,
    input  logic [WIDTH-1:0] q,
    input  logic             qM1,
    output logic [WIDTH:0]   accNext,
    output logic [WIDTH-1:0] qNext,
    output logic             qM1Next
);

    logic [WIDTH:0]     sum;
    logic [2*WIDTH+1:0] shifted;

    // Booth add/sub/no-op followed by the arithmetic right shift.
    always_comb begin
        sum = acc;
        case (boothOp(q[0], qM1))
            BOOTH_ADD: sum = acc + m;
            BOOTH_SUB: sum = acc - m;
            BOOTH_NOP: sum = acc;
            default:   sum = acc;
        endcase
        // Replicating the accumulator sign bit makes the shift arithmetic;
        // the bit dropped off the bottom of q becomes the new qM1.
        shifted = {sum[WIDTH], sum, q};
        accNext = shifted[2*WIDTH+1:WIDTH+1];
        qNext   = shifted[WIDTH:1];
        qM1Next = shifted[0];
    end

endmodule

// File: rtl/seq_booth_multiplier.sv
// -----------------------------------------------------------------------------
// seq_booth_multiplier
// Sequential signed radix-2 Booth multiplier, one partial-product step per
// clock. Shared multiply unit of the complex-multiplier datapath: start is the
// controller's startMul level, ready is its mulReady.
// Optional feature macro: ZERO_BYPASS_EN -- a zero operand finishes through a
// one-cycle ZERO state instead of WIDTH RUN cycles.
// Ports:
//   clk      in  1        clock, rising edge
//   rst      in  1        asynchronous active-high reset
//   start    in  1        request level, sampled only in IDLE
//   a        in  WIDTH    signed multiplicand, sampled with start
//   b        in  WIDTH    signed multiplier, sampled with start
//   product  out 2*WIDTH  signed a*b, registered, updated only on completion
//   ready    out 1        1 = idle / result valid
// -----------------------------------------------------------------------------
module seq_booth_multiplier
    import cmul_pkg::*;
#(
    parameter int WIDTH = CMUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               ready
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mulState_t          state, stateNext;
    logic [WIDTH:0]     acc, accNext;
    logic [WIDTH:0]     m, mNext;
    logic [WIDTH-1:0]   q, qNext;
    logic               qM1, qM1Next;
    logic [CNT_W-1:0]   count, countNext;
    logic [2*WIDTH-1:0] productNext;
    logic               readyNext;

    logic [WIDTH:0]     stepAcc;
    logic [WIDTH-1:0]   stepQ;
    logic               stepQM1;

    booth_step #(.WIDTH(WIDTH)) uStep (
        .acc     (acc),
        .m       (m),
        .q       (q),
        .qM1     (qM1),
        .accNext (stepAcc),
        .qNext   (stepQ),
        .qM1Next (stepQM1)
    );

    // State, datapath and registered outputs; reset discards any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= {(WIDTH+1){1'b0}};
            m       <= {(WIDTH+1){1'b0}};
            q       <= {WIDTH{1'b0}};
            qM1     <= 1'b0;
            count   <= {CNT_W{1'b0}};
            product <= {(2*WIDTH){1'b0}};
            ready   <= 1'b1;
        end else begin
            state   <= stateNext;
            acc     <= accNext;
            m       <= mNext;
            q       <= qNext;
            qM1     <= qM1Next;
            count   <= countNext;
            product <= productNext;
            ready   <= readyNext;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        stateNext   = state;
        accNext     = acc;
        mNext       = m;
        qNext       = q;
        qM1Next     = qM1;
        countNext   = count;
        productNext = product;
        case (state)
            IDLE: begin
                if (start) begin
                    mNext     = {a[WIDTH-1], a};
                    accNext   = {(WIDTH+1){1'b0}};
                    qNext     = b;
                    qM1Next   = 1'b0;
                    countNext = CNT_W'(WIDTH - 1);
                    stateNext = RUN;
`ifdef ZERO_BYPASS_EN
                    if ((a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}})) begin
                        stateNext = ZERO;
                    end else begin
                        stateNext = RUN;
                    end
`endif
                end else begin
                    stateNext = IDLE;
                end
            end
            RUN: begin
                accNext   = stepAcc;
                qNext     = stepQ;
                qM1Next   = stepQM1;
                countNext = count - CNT_W'(1);
                if (count == {CNT_W{1'b0}}) begin
                    // Last step: the low 2*WIDTH bits of {acc,q} are the exact product.
                    stateNext   = IDLE;
                    productNext = {stepAcc[WIDTH-1:0], stepQ};
                end else begin
                    stateNext = RUN;
                end
            end
            ZERO: begin
                stateNext   = IDLE;
                productNext = {(2*WIDTH){1'b0}};
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        // Registered ready reflects the state being entered.
        readyNext = (stateNext == IDLE);
    end

endmodule
